// File: rtl/cu_pkg.sv
// Shared control-unit definitions: bus/address widths, write addressing modes
// and the write sequencer state encoding.
package cu_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;
    localparam int R0_SEL = 0;

    localparam logic [1:0] MODE_IMM  = 2'b00;  // M[imm]      <= R0
    localparam logic [1:0] MODE_MEM  = 2'b01;  // M[M[imm]]   <= R0
    localparam logic [1:0] MODE_REG  = 2'b10;  // M[Ry]       <= R0
    localparam logic [1:0] MODE_RIND = 2'b11;  // M[R[Ry]]    <= R0

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_IMM,
        S_ADDR_MEM,
        S_LATCH_IDX,
        S_ADDR_REG,
        S_WRITE
    } wr_state_t;
endpackage

// File: rtl/mem_write_sequencer.sv
// Multi-cycle sequencer for the four write addressing modes; every path ends
// with M[addr] <= R0. Outputs are registered from the next-state decode.
module mem_write_sequencer #(
    parameter int ADDR_W = cu_pkg::ADDR_W,
    parameter int DATA_W = cu_pkg::DATA_W,
    parameter int SEL_W  = cu_pkg::SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_start,
    input  logic [1:0]        in_mode,
    input  logic [ADDR_W-1:0] in_imm,
    input  logic [SEL_W-1:0]  in_ry,
    input  logic [DATA_W-1:0] in_bus,
    input  logic              in_abort,
    output logic              out_cu_enable_out,
    output logic [DATA_W-1:0] out_cu_data,
    output logic [SEL_W-1:0]  out_reg_ry_sel,
    output logic              out_reg_read_en,
    output logic              out_data_memory_addr_wr_enable,
    output logic              out_data_memory_read_enable,
    output logic              out_data_memory_wr_enable,
    output logic              out_busy,
    output logic              out_done
);
    import cu_pkg::*;

    typedef struct packed {
        logic [1:0]        mode;
        logic [ADDR_W-1:0] imm;
        logic [SEL_W-1:0]  ry;
    } fields_t;

    wr_state_t       state_q, nxt_state;
    fields_t         cap_q, nxt_cap;
    logic [SEL_W-1:0] idx_q, nxt_idx;

    always_comb begin
        nxt_state = state_q;
        nxt_cap   = cap_q;
        nxt_idx   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (in_start && !in_abort) begin
                    nxt_cap.mode = in_mode;
                    nxt_cap.imm  = in_imm;
                    nxt_cap.ry   = in_ry;
                    case (in_mode)
                        MODE_REG:  nxt_state = S_ADDR_REG;
                        MODE_RIND: nxt_state = S_LATCH_IDX;
                        default:   nxt_state = S_ADDR_IMM;
                    endcase
                end
            end
            S_ADDR_IMM:  nxt_state = (cap_q.mode == MODE_IMM) ? S_WRITE : S_ADDR_MEM;
            S_ADDR_MEM:  nxt_state = S_WRITE;
            S_LATCH_IDX: begin
                // only the selector-width low bits of the register value index the file
                nxt_idx   = in_bus[SEL_W-1:0];
                nxt_state = S_ADDR_REG;
            end
            S_ADDR_REG:  nxt_state = S_WRITE;
            S_WRITE:     nxt_state = S_IDLE;
            default:     nxt_state = S_IDLE;
        endcase
        if (in_abort && state_q != S_IDLE)
            nxt_state = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q                        <= S_IDLE;
            cap_q                          <= '0;
            idx_q                          <= '0;
            out_cu_enable_out              <= 1'b0;
            out_cu_data                    <= '0;
            out_reg_ry_sel                 <= '0;
            out_reg_read_en                <= 1'b0;
            out_data_memory_addr_wr_enable <= 1'b0;
            out_data_memory_read_enable    <= 1'b0;
            out_data_memory_wr_enable      <= 1'b0;
            out_busy                       <= 1'b0;
            out_done                       <= 1'b0;
        end else begin
            state_q <= nxt_state;
            cap_q   <= nxt_cap;
            idx_q   <= nxt_idx;

            out_cu_enable_out              <= 1'b0;
            out_cu_data                    <= '0;
            out_reg_ry_sel                 <= '0;
            out_reg_read_en                <= 1'b0;
            out_data_memory_addr_wr_enable <= 1'b0;
            out_data_memory_read_enable    <= 1'b0;
            out_data_memory_wr_enable      <= 1'b0;
            out_busy                       <= (nxt_state != S_IDLE);
            out_done                       <= 1'b0;
            // exactly one bus owner per state: cu, register file or memory
            case (nxt_state)
                S_ADDR_IMM: begin
                    out_cu_enable_out              <= 1'b1;
                    out_cu_data                    <= DATA_W'(nxt_cap.imm);
                    out_data_memory_addr_wr_enable <= 1'b1;
                end
                S_ADDR_MEM: begin
                    out_data_memory_read_enable    <= 1'b1;
                    out_data_memory_addr_wr_enable <= 1'b1;
                end
                S_LATCH_IDX: begin
                    out_reg_ry_sel  <= nxt_cap.ry;
                    out_reg_read_en <= 1'b1;
                end
                S_ADDR_REG: begin
                    out_reg_ry_sel                 <= (nxt_cap.mode == MODE_RIND) ? nxt_idx : nxt_cap.ry;
                    out_reg_read_en                <= 1'b1;
                    out_data_memory_addr_wr_enable <= 1'b1;
                end
                S_WRITE: begin
                    out_reg_ry_sel            <= SEL_W'(R0_SEL);
                    out_reg_read_en           <= 1'b1;
                    out_data_memory_wr_enable <= 1'b1;
                    out_done                  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_write_sequencer.sv
// Directed and randomized checks of mem_write_sequencer against a small
// register-file / data-memory / address-register environment.
module tb_mem_write_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_start, in_abort;
    logic [1:0]  in_mode;
    logic [7:0]  in_imm;
    logic [2:0]  in_ry;
    logic [15:0] in_bus;
    logic        cu_en, rd_en, aw_en, mr_en, mw_en, busy, done;
    logic [15:0] cu_data;
    logic [2:0]  ry_sel;

    logic [15:0] regs [8];
    logic [15:0] mem  [256];
    logic [7:0]  addr_q = '0;
    int          wr_cnt = 0;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    mem_write_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_mode(in_mode),
        .in_imm(in_imm), .in_ry(in_ry), .in_bus(in_bus), .in_abort(in_abort),
        .out_cu_enable_out(cu_en), .out_cu_data(cu_data), .out_reg_ry_sel(ry_sel),
        .out_reg_read_en(rd_en), .out_data_memory_addr_wr_enable(aw_en),
        .out_data_memory_read_enable(mr_en), .out_data_memory_wr_enable(mw_en),
        .out_busy(busy), .out_done(done)
    );

    always_comb begin
        in_bus = '0;
        if (cu_en)      in_bus = cu_data;
        else if (rd_en) in_bus = regs[ry_sel];
        else if (mr_en) in_bus = mem[addr_q];
    end

    always @(posedge clk) begin
        if (!rst_n) mem[8'h10] <= 16'h0055;
        if (aw_en) addr_q <= in_bus[7:0];
        if (mw_en) begin
            mem[addr_q] <= in_bus;
            wr_cnt      <= wr_cnt + 1;
        end
    end

    logic [26:0] outs;
    logic [6:0]  ctl;   // {cu_en, aw, rd, mr, mw, done, busy}
    assign outs = {cu_en, cu_data, ry_sel, rd_en, aw_en, mr_en, mw_en, busy, done};
    assign ctl  = {cu_en, aw_en, rd_en, mr_en, mw_en, done, busy};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] m, input logic [7:0] imm, input logic [2:0] ry);
        in_start = 1'b1; in_mode = m; in_imm = imm; in_ry = ry;
        tick();
        in_start = 1'b0;
    endtask

    int w0, rem, acc, abt, dcnt, viol, bmis;
    logic st, ab;
    logic [1:0] md;

    initial begin
        rst_n = 1'b0; in_start = 0; in_abort = 0; in_mode = 0; in_imm = 0; in_ry = 0;
        for (int i = 0; i < 8; i++) regs[i] = 16'(i * 16'h0101);
        regs[0] = 16'hBEEF; regs[2] = 16'hFFF6; regs[5] = 16'h0020; regs[6] = 16'h0030;
        tick(); tick();
        chk("reset_outs", 32'(outs), 32'h0);
        rst_n = 1'b1;
        tick();

        // mode 00: M[0x3C] <= R0
        go(2'b00, 8'h3C, 3'd7);
        chk("m00_t1_ctl", 32'(ctl), 32'b1100001);
        chk("m00_t1_data", 32'(cu_data), 32'h003C);
        tick();
        chk("m00_t2_ctl", 32'(ctl), 32'b0010111);
        chk("m00_t2_sel", 32'(ry_sel), 32'h0);
        tick();
        chk("m00_t3_idle", 32'(ctl), 32'h0);
        chk("m00_mem", 32'(mem[8'h3C]), 32'hBEEF);

        // mode 01: M[M[0x10]] = M[0x55] <= R0
        regs[0] = 16'h1234;
        go(2'b01, 8'h10, 3'd0);
        chk("m01_t1_ctl", 32'(ctl), 32'b1100001);
        tick();
        chk("m01_t2_ctl", 32'(ctl), 32'b0101001);
        tick();
        chk("m01_t3_ctl", 32'(ctl), 32'b0010111);
        chk("m01_addr", 32'(addr_q), 32'h55);
        tick();
        chk("m01_mem", 32'(mem[8'h55]), 32'h1234);

        // mode 10: M[R5] = M[0x20] <= R0
        regs[0] = 16'hA5A5;
        go(2'b10, 8'h00, 3'd5);
        chk("m10_t1_ctl", 32'(ctl), 32'b0110001);
        chk("m10_t1_sel", 32'(ry_sel), 32'h5);
        tick();
        chk("m10_t2_ctl", 32'(ctl), 32'b0010111);
        chk("m10_t2_sel", 32'(ry_sel), 32'h0);
        tick();
        chk("m10_mem", 32'(mem[8'h20]), 32'hA5A5);

        // mode 11: R2=0xFFF6 -> index 6, M[R6] = M[0x30] <= R0
        regs[0] = 16'h7E01;
        go(2'b11, 8'h00, 3'd2);
        chk("m11_t1_ctl", 32'(ctl), 32'b0010001);
        chk("m11_t1_sel", 32'(ry_sel), 32'h2);
        tick();
        chk("m11_t2_ctl", 32'(ctl), 32'b0110001);
        chk("m11_t2_sel", 32'(ry_sel), 32'h6);
        tick();
        chk("m11_t3_ctl", 32'(ctl), 32'b0010111);
        tick();
        chk("m11_mem", 32'(mem[8'h30]), 32'h7E01);

        // start while busy is dropped
        w0 = wr_cnt;
        go(2'b10, 8'h00, 3'd5);
        go(2'b00, 8'h77, 3'd0);
        chk("busy_start_done", 32'(done), 32'h1);
        tick();
        chk("busy_start_idle", 32'(outs), 32'h0);
        chk("busy_start_wr", 32'(wr_cnt - w0), 32'h1);

        // abort in ADDR_MEM
        w0 = wr_cnt;
        go(2'b01, 8'h10, 3'd0);
        tick();
        chk("abort_in_mem", 32'(ctl), 32'b0101001);
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        chk("abort_outs", 32'(outs), 32'h0);
        tick();
        chk("abort_outs2", 32'(outs), 32'h0);
        chk("abort_no_wr", 32'(wr_cnt - w0), 32'h0);

        // abort and start together in IDLE
        in_abort = 1'b1;
        go(2'b00, 8'h3C, 3'd0);
        in_abort = 1'b0;
        chk("abort_start_idle", 32'(outs), 32'h0);

        // reset during ADDR_REG
        w0 = wr_cnt;
        go(2'b10, 8'h00, 3'd5);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 32'(outs), 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_rel_outs", 32'(outs), 32'h0);
        tick();
        chk("rst_no_wr", 32'(wr_cnt - w0), 32'h0);

        // random back-to-back traffic against a cycle-count model
        rem = 0; acc = 0; abt = 0; dcnt = 0; viol = 0; bmis = 0;
        for (int i = 0; i < 10000; i++) begin
            st = ($urandom_range(0, 1) == 0);
            ab = ($urandom_range(0, 15) == 0);
            md = 2'($urandom_range(0, 3));
            in_start = st; in_abort = ab; in_mode = md;
            in_imm = 8'($urandom); in_ry = 3'($urandom);
            if (rem == 0) begin
                if (st && !ab) begin
                    rem = md[0] ? 3 : 2;
                    acc++;
                end
            end else if (ab && rem > 1) begin
                rem = 0;
                abt++;
            end else begin
                rem--;
            end
            tick();
            if (busy != (rem != 0)) bmis++;
            if (done) dcnt++;
            if (int'(cu_en) + int'(rd_en) + int'(mr_en) > 1) viol++;
        end
        in_start = 0; in_abort = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) dcnt++;
        end
        chk("rnd_bus_owner", 32'(viol), 32'h0);
        chk("rnd_busy", 32'(bmis), 32'h0);
        chk("rnd_done_cnt", 32'(dcnt), 32'(acc - abt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_write_sequencer.md
# mem_write_sequencer

Multi-cycle sequencer for the four `write` addressing modes of the processor; every mode ends in `M[addr] <= R0`. Decode hands it a mode, an immediate and a register selector. It then drives the register file, the constant driver on the shared bus and the data-memory enables, one bus owner per cycle, until the store completes. It sits inside the control unit beside the fetch/decode logic, which stalls on `out_busy`.

## Interface
Parameters:
- `ADDR_W`, 8: data-memory address / immediate width
- `DATA_W`, 16: shared bus width
- `SEL_W`, 3: register selector width (8 registers)

Ports:
- `clk`  in  1  single clock; everything samples on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_start`  in  1  one-cycle request from decode
- `in_mode`  in  2  00 imm `M`, 01 mem-indirect `[M]`, 10 register `Ry`, 11 reg-indirect `[Ry]`
- `in_imm`  in  ADDR_W  immediate `M` from the IR
- `in_ry`  in  SEL_W  register selector from the IR
- `in_bus`  in  DATA_W  shared bus, read back for index latching
- `in_abort`  in  1  synchronous cancel
- `out_cu_enable_out`  out  1  control unit drives `out_cu_data` onto the bus
- `out_cu_data`  out  DATA_W  zero-extended immediate
- `out_reg_ry_sel`  out  SEL_W  register-file read selector
- `out_reg_read_en`  out  1  register file drives the bus
- `out_data_memory_addr_wr_enable`  out  1  memory address register loads from the bus
- `out_data_memory_read_enable`  out  1  memory drives the bus
- `out_data_memory_wr_enable`  out  1  memory writes the bus at the current address
- `out_busy`  out  1  sequence in progress
- `out_done`  out  1  high in the cycle the store happens

## Operation
- Moore FSM. All outputs decode from the state register plus the captured fields.
- States: IDLE, ADDR_IMM, ADDR_MEM, LATCH_IDX, ADDR_REG, WRITE.
- IDLE: if `in_start`, capture `in_mode`, `in_imm` and `in_ry`, then go to:
  - ADDR_IMM for modes 00 and 01
  - ADDR_REG for mode 10
  - LATCH_IDX for mode 11
- ADDR_IMM: `out_cu_enable_out`=1, `out_cu_data`={0,imm}, `addr_wr_enable`=1. Next state is WRITE for mode 00, ADDR_MEM for mode 01.
- ADDR_MEM: `out_data_memory_read_enable`=1, `addr_wr_enable`=1, so the address register loads `M[M]`. Next state WRITE.
- LATCH_IDX: `ry_sel`=ry, `reg_read_en`=1. The internal index register loads `in_bus[SEL_W-1:0]`. Next state ADDR_REG.
- ADDR_REG: `ry_sel` = ry for mode 10, the latched index for mode 11. Also `reg_read_en`=1 and `addr_wr_enable`=1. Next state WRITE.
- WRITE: `ry_sel`=0, `reg_read_en`=1, `data_memory_wr_enable`=1, `out_done`=1. Next state IDLE.
- Bus invariant: at most one of `out_cu_enable_out`, `out_reg_read_en` and `out_data_memory_read_enable` is high in any cycle.
- Outside IDLE, `out_busy`=1. `in_start` arriving while busy is ignored, not queued.
- `in_abort` in any non-IDLE state sends the FSM to IDLE on the next edge and the WRITE is not performed. If `in_abort` and `in_start` arrive together in IDLE, abort wins and the start is dropped.
- Captured fields and the index register hold their values until the next accepted start.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE, every output 0, `out_cu_data`=0, captured fields and index register 0. Asserting reset mid-sequence drops the store immediately; no partial write follows release.
- Start accepted at edge T. The first control state is active in cycle T+1.
- Store cycle (`out_done`=1): T+2 for modes 00 and 10, T+3 for modes 01 and 11.
- Back-to-back: the FSM is in IDLE in the cycle after WRITE. A start in that cycle is accepted, so the store-to-store period is 3 or 4 cycles.
- Bus data is sampled on the edge that ends LATCH_IDX. Only the low SEL_W bits are used; the upper bits are ignored.

## Structure
- Shared package `cu_pkg`: state enum, the four `MODE_*` constants, `SEL_W`, `ADDR_W`, `DATA_W`, `R0_SEL`=0.
- Single module with no sub-module. One register holds the state, one holds the captured fields and one holds the index.

## Test plan
- Mode 00, imm=0x3C: T+1 has `cu_enable_out`, `addr_wr`, bus=0x003C. T+2 has `ry_sel`=0, `reg_read_en`, `mem_wr`, `done`. T+3 is IDLE.
- Mode 01, imm=0x10, model `M[0x10]`=0x55: the address register loads 0x55 at T+2 and the store at T+3 targets 0x55 with R0's value.
- Mode 10, ry=5: T+1 has `ry_sel`=5 with `addr_wr`. T+2 has `ry_sel`=0 and `mem_wr`. The model shows `M[R5]` = R0.
- Mode 11, ry=2, R2=0xFFF6: the index latches 6 and T+2 has `ry_sel`=6. The store goes to `M[R6]`.
- `in_start` pulsed during busy, `in_abort` in ADDR_MEM, and `rst_n` low in ADDR_REG: none produces `mem_wr`, and all outputs are 0 after abort or reset.
- Random modes back-to-back for 10k cycles: the bus-owner invariant holds, and `done` count equals accepted starts minus aborts.
